spi_apb_fifo_if: RTL and testbench

SPI_APB_FIFO_IF -- requirements
Module: spi_apb_fifo_if

---
 rtl/spi_apb_fifo_if_if.sv | 13 +
 rtl/spi_apb_fifo_if.sv | 115 +++++++++++
 tb/tb_spi_apb_fifo_if.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/spi_apb_fifo_if_if.sv
// spi_apb_fifo_if_if: APB3 bus bundle (PSEL/PENABLE/PWRITE/PADDR/PWDATA in, PRDATA/PREADY/PSLVERR out) with master/slave views
interface spi_apb_fifo_if_if #(parameter int DATA_W = 8);
  logic              PSEL_i;
  logic              PENABLE_i;
  logic              PWRITE_i;
  logic [2:0]        PADDR_i;
  logic [DATA_W-1:0] PWDATA_i;
  logic [DATA_W-1:0] PRDATA_o;
  logic              PREADY_o;
  logic              PSLVERR_o;
  modport master(output PSEL_i, PENABLE_i, PWRITE_i, PADDR_i, PWDATA_i, input PRDATA_o, PREADY_o, PSLVERR_o);
  modport slave(input PSEL_i, PENABLE_i, PWRITE_i, PADDR_i, PWDATA_i, output PRDATA_o, PREADY_o, PSLVERR_o);
endinterface

// File: rtl/spi_apb_fifo_if.sv
// spi_apb_fifo_if: APB3 register file (CR1/CR2/BR/SR/DR) with TX/RX FIFOs, mode FSM and irq; ports: PCLK, PRESET_n, apb (slave), CR1/BR field outputs, spi_mode_o, TX/RX shifter handshake, ss_i, irq_o
module spi_apb_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 PCLK,
  input  logic                 PRESET_n,
  spi_apb_fifo_if_if.slave     apb,
  output logic                 mstr_o,
  output logic                 cpol_o,
  output logic                 cpha_o,
  output logic                 lsbfe_o,
  output logic [2:0]           sppr_o,
  output logic [2:0]           spr_o,
  output logic [1:0]           spi_mode_o,
  output logic [DATA_W-1:0]    tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  input  logic [DATA_W-1:0]    rx_data_i,
  input  logic                 rx_valid_i,
  input  logic                 ss_i,
  output logic                 irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_st_t;
  typedef enum logic [1:0] {RUN = 2'b00, WAIT = 2'b01, STOP = 2'b10} mode_t;
  apb_st_t           r_apb;
  mode_t             r_mode;
  logic [7:0]        r_cr1, r_cr2, r_br;
  logic              r_ovr;
  logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW:0]       r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic w_acc, w_dr, w_err, w_wr, w_rd;
  logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_on;
  logic w_ovr_set, w_ovr_clr, w_modf;
  logic [7:0] w_sr, w_reg;
  assign w_acc      = r_apb == ACCESS;
  assign w_dr       = apb.PADDR_i == 3'd4;
  assign w_tx_empty = r_tx_wp == r_tx_rp;
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
  assign w_rx_empty = r_rx_wp == r_rx_rp;
  assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
  // An erroring access is masked out of w_wr/w_rd so it cannot touch any state.
  assign w_err = w_acc & ((apb.PADDR_i > 3'd4) | (w_dr & apb.PWRITE_i & w_tx_full) | (w_dr & !apb.PWRITE_i & w_rx_empty));
  assign w_wr  = w_acc & apb.PWRITE_i & !w_err;
  assign w_rd  = w_acc & !apb.PWRITE_i & !w_err;
  assign w_tx_push = w_wr & w_dr;
  assign w_rx_pop  = w_rd & w_dr;
  assign tx_valid_o = !w_tx_empty & (r_mode != STOP);
  assign tx_data_o  = r_tx_mem[r_tx_rp[AW-1:0]];
  assign w_tx_pop   = tx_valid_o & tx_ready_i;
  // A full RX FIFO still accepts a word when the same cycle pops one.
  assign w_rx_on   = rx_valid_i & (r_mode != STOP);
  assign w_rx_push = w_rx_on & (!w_rx_full | w_rx_pop);
  assign w_ovr_set = w_rx_on & w_rx_full & !w_rx_pop;
  assign w_ovr_clr = w_wr & (apb.PADDR_i == 3'd3) & apb.PWDATA_i[6];
  assign w_modf    = !ss_i & r_cr1[4] & r_cr2[4] & !r_cr1[1];
  assign w_sr  = {!w_rx_empty, r_ovr, w_tx_empty, w_modf, w_tx_full, w_rx_full, 2'b00};
  assign w_reg = apb.PADDR_i == 3'd0 ? r_cr1 :
                 apb.PADDR_i == 3'd1 ? r_cr2 :
                 apb.PADDR_i == 3'd2 ? r_br  :
                 apb.PADDR_i == 3'd3 ? w_sr  : 8'h00;
  assign apb.PRDATA_o  = !w_rd ? '0 : w_dr ? r_rx_mem[r_rx_rp[AW-1:0]] : DATA_W'(w_reg);
  assign apb.PREADY_o  = w_acc;
  assign apb.PSLVERR_o = w_err;
  assign mstr_o     = r_cr1[4];
  assign cpol_o     = r_cr1[3];
  assign cpha_o     = r_cr1[2];
  assign lsbfe_o    = r_cr1[0];
  assign sppr_o     = r_br[6:4];
  assign spr_o      = r_br[2:0];
  assign spi_mode_o = r_mode;
  assign irq_o      = (r_cr1[7] & (!w_rx_empty | w_modf | r_ovr)) | (r_cr1[5] & w_tx_empty);
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      r_apb   <= IDLE;
      r_mode  <= RUN;
      r_cr1   <= 8'h04;
      r_cr2   <= 8'h00;
      r_br    <= 8'h00;
      r_ovr   <= 1'b0;
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      case (r_apb)
        IDLE:    r_apb <= (apb.PSEL_i & !apb.PENABLE_i) ? SETUP : IDLE;
        SETUP:   r_apb <= !apb.PSEL_i ? IDLE : apb.PENABLE_i ? ACCESS : SETUP;
        ACCESS:  r_apb <= apb.PSEL_i ? SETUP : IDLE;
        default: r_apb <= IDLE;
      endcase
      case (r_mode)
        RUN:     r_mode <= !r_cr1[6] ? WAIT : RUN;
        WAIT:    r_mode <= r_cr1[6] ? RUN : r_cr2[1] ? STOP : WAIT;
        STOP:    r_mode <= r_cr1[6] ? RUN : !r_cr2[1] ? WAIT : STOP;
        default: r_mode <= RUN;
      endcase
      if (w_wr && apb.PADDR_i == 3'd0) r_cr1 <= apb.PWDATA_i[7:0];
      if (w_wr && apb.PADDR_i == 3'd1) r_cr2 <= apb.PWDATA_i[7:0] & 8'h1B;
      if (w_wr && apb.PADDR_i == 3'd2) r_br  <= apb.PWDATA_i[7:0] & 8'h77;
      r_ovr <= w_ovr_set | (r_ovr & !w_ovr_clr);
      if (w_tx_push) r_tx_wp <= r_tx_wp + (AW+1)'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + (AW+1)'(1);
      if (w_rx_push) r_rx_wp <= r_rx_wp + (AW+1)'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + (AW+1)'(1);
    end
  end
  always_ff @(posedge PCLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= apb.PWDATA_i;
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= rx_data_i;
  end
endmodule

// File: tb/tb_spi_apb_fifo_if.sv
// tb_spi_apb_fifo_if: scoreboard bench for spi_apb_fifo_if driving APB, TX/RX handshakes and ss_i
module tb_spi_apb_fifo_if;
  localparam int DW = 8, DEPTH = 4;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  spi_apb_fifo_if_if #(.DATA_W(DW)) bus();
  logic mstr, cpol, cpha, lsbfe, tx_valid, tx_ready, rx_valid, ss, irq;
  logic [2:0] sppr, spr;
  logic [1:0] mode;
  logic [DW-1:0] tx_data, rx_data;
  spi_apb_fifo_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .PCLK(clk), .PRESET_n(rst_n), .apb(bus),
    .mstr_o(mstr), .cpol_o(cpol), .cpha_o(cpha), .lsbfe_o(lsbfe),
    .sppr_o(sppr), .spr_o(spr), .spi_mode_o(mode),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .ss_i(ss), .irq_o(irq)
  );
  int errors = 0, checks = 0;
  logic [DW-1:0] tx_q[$], rx_q[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      check("tx_expected", tx_q.size() != 0, 1'b1);
      if (tx_q.size() != 0) check("tx_data", tx_data, tx_q.pop_front());
    end
  end
  task automatic apb(input logic wr, input logic [2:0] a, input logic [DW-1:0] d,
                     output logic [DW-1:0] rd, output logic err);
    int n;
    @(posedge clk); #1;
    bus.PSEL_i = 1; bus.PENABLE_i = 0; bus.PWRITE_i = wr; bus.PADDR_i = a; bus.PWDATA_i = d;
    @(posedge clk); #1;
    bus.PENABLE_i = 1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.PREADY_o && n < 8);
    if (!bus.PREADY_o) check("pready_timeout", bus.PREADY_o, 1'b1);
    rd = bus.PRDATA_o;
    err = bus.PSLVERR_o;
    @(posedge clk); #1;
    bus.PSEL_i = 0; bus.PENABLE_i = 0;
  endtask
  task automatic wr(input logic [2:0] a, input logic [DW-1:0] d, input logic exp_err);
    logic [DW-1:0] rd;
    logic err;
    if (a == 3'd4 && !exp_err) tx_q.push_back(d);
    apb(1'b1, a, d, rd, err);
    check("wr_err", err, exp_err);
    check("wr_prdata", rd, 0);
  endtask
  task automatic rdc(input string tag, input logic [2:0] a, input logic [DW-1:0] exp, input logic exp_err);
    logic [DW-1:0] rd;
    logic err;
    apb(1'b0, a, '0, rd, err);
    check(tag, rd, exp);
    check({tag, "_err"}, err, exp_err);
  endtask
  task automatic rd_dr();
    logic exp_err;
    logic [DW-1:0] exp;
    exp_err = rx_q.size() == 0;
    exp = exp_err ? '0 : rx_q.pop_front();
    rdc("dr_read", 3'd4, exp, exp_err);
  endtask
  task automatic rx_send(input logic [DW-1:0] d, input logic stop);
    @(posedge clk); #1;
    rx_valid = 1; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 0;
    if (!stop && rx_q.size() < DEPTH) rx_q.push_back(d);
  endtask
  task automatic drain_tx();
    tx_ready = 1;
    for (int i = 0; i < 20 && tx_q.size() != 0; i++) @(posedge clk);
    check("tx_drained", tx_q.size(), 0);
    @(posedge clk); #1;
    tx_ready = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    bus.PSEL_i = 0; bus.PENABLE_i = 0; bus.PWRITE_i = 0; bus.PADDR_i = 0; bus.PWDATA_i = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0; ss = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pready", bus.PREADY_o, 0);
    check("rst_pslverr", bus.PSLVERR_o, 0);
    check("rst_prdata", bus.PRDATA_o, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_irq", irq, 0);
    check("rst_cpha", cpha, 1);
    check("rst_cr1_outs", {mstr, cpol, lsbfe, sppr, spr}, 0);
    check("rst_mode", mode, 0);
    rst_n = 1;
    rdc("sr_rst", 3'd3, 8'h20, 0);
    rdc("cr1_rst", 3'd0, 8'h04, 0);
    wr(3'd2, 8'hFF, 0);
    rdc("br_mask", 3'd2, 8'h77, 0);
    check("br_outs", {sppr, spr}, 6'h3F);
    wr(3'd2, 8'h00, 0);
    wr(3'd1, 8'hFF, 0);
    rdc("cr2_mask", 3'd1, 8'h1B, 0);
    wr(3'd1, 8'h00, 0);
    wr(3'd4, 8'hA1, 0);
    wr(3'd4, 8'hB2, 0);
    wr(3'd4, 8'hC3, 0);
    wr(3'd4, 8'hD4, 0);
    rdc("sr_txfull", 3'd3, 8'h08, 0);
    wr(3'd4, 8'hE5, 1);
    rdc("sr_txfull_kept", 3'd3, 8'h08, 0);
    drain_tx();
    rdc("sr_sptef", 3'd3, 8'h20, 0);
    check("tx_valid_empty", tx_valid, 0);
    for (int i = 1; i <= 5; i++) rx_send(DW'(i), 0);
    rdc("sr_ovr", 3'd3, 8'hE4, 0);
    repeat (4) rd_dr();
    rd_dr();
    rdc("sr_ovr_held", 3'd3, 8'h60, 0);
    wr(3'd3, 8'h40, 0);
    rdc("sr_ovr_clr", 3'd3, 8'h20, 0);
    wr(3'd0, 8'hC0, 0);
    check("irq_c0_idle", irq, 0);
    wr(3'd0, 8'hE0, 0);
    check("irq_sptef", irq, 1);
    wr(3'd0, 8'hC0, 0);
    check("irq_c0_again", irq, 0);
    rx_send(8'h77, 0);
    check("irq_spif", irq, 1);
    rd_dr();
    wr(3'd4, 8'h5A, 0);
    check("tx_valid_run", tx_valid, 1);
    wr(3'd1, 8'h02, 0);
    check("mode_run", mode, 2'b00);
    wr(3'd0, 8'h00, 0);
    check("mode_still_run", mode, 2'b00);
    @(posedge clk); #1;
    check("mode_wait", mode, 2'b01);
    @(posedge clk); #1;
    check("mode_stop", mode, 2'b10);
    tx_ready = 1;
    check("tx_valid_stop", tx_valid, 0);
    rx_send(8'h99, 1);
    rdc("sr_stop", 3'd3, 8'h00, 0);
    wr(3'd0, 8'h40, 0);
    check("mode_stop_held", mode, 2'b10);
    @(posedge clk); #1;
    check("mode_resume", mode, 2'b00);
    check("tx_valid_resume", tx_valid, 1);
    drain_tx();
    wr(3'd1, 8'h10, 0);
    wr(3'd0, 8'h10, 0);
    ss = 0;
    rdc("sr_modf", 3'd3, 8'h30, 0);
    check("irq_modf_masked", irq, 0);
    wr(3'd0, 8'h90, 0);
    check("irq_modf", irq, 1);
    check("mstr_out", mstr, 1);
    wr(3'd6, 8'h55, 1);
    rdc("cr1_after_err", 3'd0, 8'h90, 0);
    rdc("cr2_after_err", 3'd1, 8'h10, 0);
    rdc("addr5_err", 3'd5, 8'h00, 1);
    rd_dr();
    ss = 1;
    rdc("sr_no_modf", 3'd3, 8'h20, 0);
    wr(3'd4, 8'h11, 0);
    rx_send(8'h22, 0);
    rdc("sr_pre_rst", 3'd3, 8'h80, 0);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check("async_tx_valid", tx_valid, 0);
    check("async_irq", irq, 0);
    check("async_cpha", cpha, 1);
    tx_q.delete();
    rx_q.delete();
    @(posedge clk); #1;
    rst_n = 1;
    rdc("sr_post_rst", 3'd3, 8'h20, 0);
    rd_dr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
